// File: rtl/fetch_queue_if.sv
// Instruction-bus and decode-side bundle for the fetch front end.
// The fetch unit drives the request and the decode register; the bus returns responses.
interface fetch_queue_if;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] raw_instr;
   } fetch_data_t;

   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   fetch_data_t dataF;

   modport master (output ireq, output dataF, input iresp);
   modport slave  (input ireq, input dataF, output iresp);
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: a DEPTH-entry prefetch FIFO between the ibus and decode,
// squashing the response of a request that a branch overtook while it was in flight.
module fetch_queue #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          branch,
   input  logic [63:0]   jump,
   input  logic          stall,
   fetch_queue_if.master bus
);
   localparam int unsigned      PTR_W = $clog2(DEPTH);
   localparam int unsigned      CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   logic [63:0]      fifo_pc_q    [DEPTH];
   logic [31:0]      fifo_instr_q [DEPTH];
   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic [63:0]      redirect_pc_q, redirect_pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             drop_q, drop_d;
   logic             dataf_valid_q, dataf_valid_d;
   logic [63:0]      dataf_pc_q, dataf_pc_d;
   logic [31:0]      dataf_instr_q, dataf_instr_d;
   logic             ireq_valid, data_ok, fire, push, pop;

   assign data_ok   = bus.iresp.data_ok;
   assign bus.ireq  = {ireq_valid, fetch_pc_q};
   assign bus.dataF = {dataf_valid_q, dataf_pc_q, dataf_instr_q};

   always_comb begin
      // A squashed request must still be held until its data_ok, even with a full FIFO
      ireq_valid    = !reset && (drop_q || (count_q < FULL));
      fire          = ireq_valid && data_ok;
      push          = fire && !drop_q && !branch;
      pop           = !branch && !stall && (count_q != '0);

      fetch_pc_d    = fetch_pc_q;
      redirect_pc_d = redirect_pc_q;
      drop_d        = drop_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (branch) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (ireq_valid && !data_ok) begin
            drop_d        = 1'b1;
            redirect_pc_d = jump;
         end else begin
            fetch_pc_d = jump;
            drop_d     = 1'b0;
         end
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
         count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
         if (fire && drop_q) begin
            fetch_pc_d = redirect_pc_q;
            drop_d     = 1'b0;
         end else if (push) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
         end
      end

      dataf_valid_d = dataf_valid_q;
      dataf_pc_d    = dataf_pc_q;
      dataf_instr_d = dataf_instr_q;
      if (branch) begin
         dataf_valid_d = 1'b0;
      end else if (!stall) begin
         dataf_valid_d = pop;
         if (pop) begin
            dataf_pc_d    = fifo_pc_q[rd_ptr_q];
            dataf_instr_d = fifo_instr_q[rd_ptr_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         drop_q        <= 1'b0;
         dataf_valid_q <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         drop_q        <= drop_d;
         dataf_valid_q <= dataf_valid_d;
      end
   end

   // Payload registers carry no reset; their valid qualifiers above do
   always_ff @(posedge clk) begin
      redirect_pc_q <= redirect_pc_d;
      dataf_pc_q    <= dataf_pc_d;
      dataf_instr_q <= dataf_instr_d;
      if (push) begin
         fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
         fifo_instr_q[wr_ptr_q] <= bus.iresp.data;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table on a zero-wait bus, then hand-built
// sequences for stall fill, squashed redirects and FIFO wrap on DEPTH=2/8 builds.
module tb_fetch_queue;
   localparam logic [63:0] R = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        reset, branch, stall, reset_w, stall_w;
   logic [63:0] jump;
   int          lat, wait_cnt, fire_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   fetch_queue_if bif ();
   fetch_queue_if bif2 ();
   fetch_queue_if bif8 ();

   fetch_queue #(.RESET_PC(R), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .branch(branch), .jump(jump), .stall(stall), .bus(bif));
   fetch_queue #(.RESET_PC(R), .DEPTH(2)) u2 (
      .clk(clk), .reset(reset_w), .branch(1'b0), .jump(64'd0), .stall(stall_w), .bus(bif2));
   fetch_queue #(.RESET_PC(R), .DEPTH(8)) u8 (
      .clk(clk), .reset(reset_w), .branch(1'b0), .jump(64'd0), .stall(stall_w), .bus(bif8));

   // Bus model: data_ok after lat waiting cycles, data = low word of the address
   assign bif.iresp  = {bif.ireq.valid && (wait_cnt >= lat), bif.ireq.addr[31:0]};
   assign bif2.iresp = {bif2.ireq.valid, bif2.ireq.addr[31:0]};
   assign bif8.iresp = {bif8.ireq.valid, bif8.ireq.addr[31:0]};

   always @(posedge clk) begin
      if (reset || !bif.ireq.valid || bif.iresp.data_ok) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
      if (reset) fire_cnt <= 0;
      else if (bif.ireq.valid && bif.iresp.data_ok) fire_cnt <= fire_cnt + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // A pending request must keep valid and addr stable until its data_ok
   logic        pend_q;
   logic [63:0] pend_addr_q;
   always @(posedge clk) begin
      pend_q      <= !reset && bif.ireq.valid && !bif.iresp.data_ok;
      pend_addr_q <= bif.ireq.addr;
   end
   always @(negedge clk) begin
      if (pend_q && !reset) begin
         chk("bus_hold_valid", bif.ireq.valid, 1);
         chk("bus_hold_addr", bif.ireq.addr, pend_addr_q);
      end
   end

   task automatic do_reset(input logic st);
      reset  = 1'b1;
      branch = 1'b0;
      jump   = '0;
      stall  = st;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ireq_valid", bif.ireq.valid, 0);
      chk("rst_dataf_valid", bif.dataF.valid, 0);
      reset = 1'b0;
      #1;
      chk("first_req_valid", bif.ireq.valid, 1);
      chk("first_req_addr", bif.ireq.addr, R);
   endtask

   typedef struct {
      logic        br;
      logic [63:0] jmp;
      logic        st;
      logic        dv;
      logic [63:0] dpc;
      logic        iv;
      logic [63:0] addr;
   } vec_t;

   vec_t tbl [18];

   initial begin
      bit found;
      int n2, n8;
      logic [63:0] exp2, exp8;

      reset_w = 1'b1;
      stall_w = 1'b0;
      tbl[0]  = '{1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, R + 64'h4};
      tbl[1]  = '{1'b0, 64'd0, 1'b0, 1'b1, R, 1'b1, R + 64'h8};
      tbl[2]  = '{1'b0, 64'd0, 1'b0, 1'b1, R + 64'h4, 1'b1, R + 64'hC};
      tbl[3]  = '{1'b0, 64'd0, 1'b1, 1'b1, R + 64'h4, 1'b1, R + 64'h10};
      tbl[4]  = '{1'b0, 64'd0, 1'b1, 1'b1, R + 64'h4, 1'b1, R + 64'h14};
      tbl[5]  = '{1'b0, 64'd0, 1'b1, 1'b1, R + 64'h4, 1'b0, R + 64'h18};
      tbl[6]  = '{1'b0, 64'd0, 1'b1, 1'b1, R + 64'h4, 1'b0, R + 64'h18};
      tbl[7]  = '{1'b0, 64'd0, 1'b0, 1'b1, R + 64'h8, 1'b1, R + 64'h18};
      tbl[8]  = '{1'b0, 64'd0, 1'b0, 1'b1, R + 64'hC, 1'b1, R + 64'h1C};
      tbl[9]  = '{1'b1, R + 64'h1000, 1'b0, 1'b0, 64'd0, 1'b1, R + 64'h1000};
      tbl[10] = '{1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, R + 64'h1004};
      tbl[11] = '{1'b0, 64'd0, 1'b0, 1'b1, R + 64'h1000, 1'b1, R + 64'h1008};
      tbl[12] = '{1'b1, R + 64'h2000, 1'b1, 1'b0, 64'd0, 1'b1, R + 64'h2000};
      tbl[13] = '{1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, R + 64'h2004};
      tbl[14] = '{1'b0, 64'd0, 1'b0, 1'b1, R + 64'h2000, 1'b1, R + 64'h2008};
      tbl[15] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
      tbl[16] = '{1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 64'd0};
      tbl[17] = '{1'b0, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h4};

      // Zero-wait bus vector table
      lat = 0;
      do_reset(1'b0);
      for (int i = 0; i < 18; i++) begin
         branch = tbl[i].br;
         jump   = tbl[i].jmp;
         stall  = tbl[i].st;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_dv", i), bif.dataF.valid, tbl[i].dv);
         if (tbl[i].dv) begin
            chk($sformatf("vec%0d_pc", i), bif.dataF.pc, tbl[i].dpc);
            chk($sformatf("vec%0d_instr", i), bif.dataF.raw_instr, {32'd0, tbl[i].dpc[31:0]});
         end
         chk($sformatf("vec%0d_iv", i), bif.ireq.valid, tbl[i].iv);
         chk($sformatf("vec%0d_addr", i), bif.ireq.addr, tbl[i].addr);
      end

      // Stall for 10 cycles from reset: exactly DEPTH requests accepted, then drain in order
      do_reset(1'b1);
      repeat (10) @(posedge clk);
      #1;
      chk("stall_fire_cnt", fire_cnt, 4);
      chk("stall_ireq_valid", bif.ireq.valid, 0);
      chk("stall_dataf_valid", bif.dataF.valid, 0);
      stall = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("drain%0d_dv", k), bif.dataF.valid, 1);
         chk($sformatf("drain%0d_pc", k), bif.dataF.pc, R + 64'(4 * k));
         if (k == 0) chk("drain_resume_addr", bif.ireq.addr, R + 64'h10);
      end

      // 3-cycle bus, branch one cycle after issue: response squashed, addr held
      lat = 3;
      do_reset(1'b0);
      @(posedge clk);
      #1;
      branch = 1'b1;
      jump   = R + 64'h1000;
      @(posedge clk);
      #1;
      branch = 1'b0;
      chk("sqA_hold_addr", bif.ireq.addr, R);
      @(posedge clk);
      #1;
      chk("sqA_hold_addr2", bif.ireq.addr, R);
      @(posedge clk);
      #1;
      chk("sqA_new_addr", bif.ireq.addr, R + 64'h1000);
      chk("sqA_no_dataf", bif.dataF.valid, 0);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         if (bif.dataF.valid) begin
            found = 1;
            chk("sqA_first_pc", bif.dataF.pc, R + 64'h1000);
         end
      end
      chk("sqA_seen", found, 1);

      // Two redirects during one pending request: the last one wins
      do_reset(1'b0);
      branch = 1'b1;
      jump   = R + 64'h1000;
      @(posedge clk);
      #1;
      jump = R + 64'h2000;
      @(posedge clk);
      #1;
      branch = 1'b0;
      for (int k = 0; k < 10 && bif.ireq.addr == R; k++) begin
         @(posedge clk);
         #1;
      end
      chk("sqB_new_addr", bif.ireq.addr, R + 64'h2000);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         if (bif.dataF.valid) begin
            found = 1;
            chk("sqB_first_pc", bif.dataF.pc, R + 64'h2000);
         end
      end
      chk("sqB_seen", found, 1);

      // DEPTH=2 and DEPTH=8: random stall, in-order pc stream across many wraps
      repeat (2) @(posedge clk);
      #1;
      reset_w = 1'b0;
      exp2 = R;
      exp8 = R;
      n2 = 0;
      n8 = 0;
      for (int c = 0; c < 300; c++) begin
         stall_w = ($urandom_range(0, 2) == 0);
         @(posedge clk);
         #1;
         if (!stall_w && bif2.dataF.valid) begin
            chk("wrap2_pc", bif2.dataF.pc, exp2);
            chk("wrap2_instr", bif2.dataF.raw_instr, {32'd0, exp2[31:0]});
            exp2 += 64'd4;
            n2++;
         end
         if (!stall_w && bif8.dataF.valid) begin
            chk("wrap8_pc", bif8.dataF.pc, exp8);
            exp8 += 64'd4;
            n8++;
         end
      end
      chk("wrap2_pops", n2 >= 6, 1);
      chk("wrap8_pops", n8 >= 24, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
